// File: rtl/regfile_initiator_if.sv
//------------------------------------------------------------------------------
// Module      : regfile_initiator_if
// Description : req/ack bus between the register-file initiator and responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_initiator_if;
    logic       req;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

`default_nettype wire

// File: rtl/regfile_initiator.sv
//------------------------------------------------------------------------------
// Module      : regfile_initiator
// Description : Debounced push-button to one req/ack register-file transaction.
//               Optional ack timeout enabled by REGFILE_INIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_initiator #(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 15
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                key_n,
    input  wire logic                sw_we,
    input  wire logic [1:0]          sw_addr,
    input  wire logic [3:0]          sw_data,
    regfile_initiator_if.master      bus,
    output logic      [7:0]          rd_q,
    output logic                     done,
    output logic                     busy,
    output logic                     err
);

    localparam logic [1:0] S_ARM     = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    // Illegal parameter values leave an empty marker scope in the hierarchy.
    if (DEB_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
    end

    logic [1:0]       state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [1:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rd_q_q, rd_q_d;
    logic             done_q, done_d;
    logic             key_s;

`ifdef REGFILE_INIT_TIMEOUT_EN
    localparam int                TCNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_q, err_d;
`endif

    assign key_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ARM;
            sync_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q_q  <= '0;
            done_q  <= 1'b0;
`ifdef REGFILE_INIT_TIMEOUT_EN
            tcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q_q  <= rd_q_d;
            done_q  <= done_d;
`ifdef REGFILE_INIT_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], key_n};
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_q_d  = rd_q_q;
        done_d  = 1'b0;
`ifdef REGFILE_INIT_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_ARM: begin
                if (key_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    // Command is captured only here; later switch moves are ignored.
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = sw_we;
                    addr_d  = sw_addr;
                    wdata_d = {{4{sw_data[3]}}, sw_data};
`ifdef REGFILE_INIT_TIMEOUT_EN
                    tcnt_d  = '0;
                    err_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.ack) begin
                    state_d = S_RELEASE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rd_q_d = bus.rdata;
                    end
`ifdef REGFILE_INIT_TIMEOUT_EN
                end else if (tcnt_q == TO_LAST) begin
                    state_d = S_RELEASE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
`endif
                end
            end
            S_RELEASE: begin
                // Key must read released for DEB_CYCLES edges in a row before re-arming.
                if (!key_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_ARM;
                cnt_d   = '0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.req   = req_q;
        bus.we    = we_q;
        bus.addr  = addr_q;
        bus.wdata = wdata_q;
        rd_q      = rd_q_q;
        done      = done_q;
        busy      = (state_q == S_ISSUE) || (state_q == S_RELEASE);
`ifdef REGFILE_INIT_TIMEOUT_EN
        err       = err_q;
`else
        err       = 1'b0;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_initiator.sv
//------------------------------------------------------------------------------
// Module      : tb_regfile_initiator
// Description : Directed self-checking bench for regfile_initiator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_initiator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_n;
    logic       sw_we;
    logic [1:0] sw_addr;
    logic [3:0] sw_data;
    logic [7:0] rd_q;
    logic       done;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int req_total  = 0;
    int done_total = 0;

    regfile_initiator_if bus_if ();

    regfile_initiator #(
        .DEB_CYCLES (4),
        .TIMEOUT    (15)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n   (key_n),
        .sw_we   (sw_we),
        .sw_addr (sw_addr),
        .sw_data (sw_data),
        .bus     (bus_if),
        .rd_q    (rd_q),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Running counts of req-high cycles and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.req === 1'b1) req_total  <= req_total + 1;
        if (done === 1'b1)       done_total <= done_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic we_i, input logic [1:0] a_i, input logic [3:0] d_i,
                         output int edges);
        sw_we   = we_i;
        sw_addr = a_i;
        sw_data = d_i;
        key_n   = 1'b0;
        edges   = 0;
        while (bus_if.req !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_key();
        key_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_n = 1'b1; sw_we = 1'b0; sw_addr = 2'd0; sw_data = 4'd0;
        bus_if.ack = 1'b0; bus_if.rdata = 8'h00;
        repeat (3) tick();
        n_checks++;
        if ({bus_if.req, bus_if.we, bus_if.addr, bus_if.wdata} !== 12'h000) begin
            n_fail++; $display("FAIL reset_bus: got req/we/addr/wdata %b/%b/%h/%h required 0", bus_if.req, bus_if.we, bus_if.addr, bus_if.wdata);
        end
        n_checks++;
        if ({rd_q, done, busy, err} !== 11'h000) begin
            n_fail++; $display("FAIL reset_out: got rd_q/done/busy/err %h/%b/%b/%b required 0", rd_q, done, busy, err);
        end
        rst_n = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (busy !== 1'b0 || bus_if.req !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got busy=%b req=%b required 0/0", busy, bus_if.req);
        end
    endtask

    task automatic test_clean_write();
        int e; int d0;
        d0 = done_total;
        press(1'b1, 2'd2, 4'b1010, e);
        n_checks++;
        if (e !== 6) begin
            n_fail++; $display("FAIL write_latency: got %0d edges required 6", e);
        end
        n_checks++;
        if (bus_if.we !== 1'b1 || bus_if.addr !== 2'd2 || bus_if.wdata !== 8'hFA) begin
            n_fail++; $display("FAIL write_cmd: got we/addr/wdata %b/%h/%h required 1/2/fa", bus_if.we, bus_if.addr, bus_if.wdata);
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        n_checks++;
        if (bus_if.req !== 1'b0 || done !== 1'b1) begin
            n_fail++; $display("FAIL write_ack: got req=%b done=%b required 0/1", bus_if.req, done);
        end
        sw_addr = 2'd3;
        tick();
        n_checks++;
        if (done !== 1'b0 || done_total - d0 !== 1) begin
            n_fail++; $display("FAIL write_done_once: got done=%b pulses=%0d required 0/1", done, done_total - d0);
        end
        n_checks++;
        if (rd_q !== 8'h00) begin
            n_fail++; $display("FAIL write_rd_q: got %h required 00", rd_q);
        end
        release_key();
        n_checks++;
        if (busy !== 1'b0 || bus_if.addr !== 2'd2 || bus_if.wdata !== 8'hFA) begin
            n_fail++; $display("FAIL write_hold: got busy/addr/wdata %b/%h/%h required 0/2/fa", busy, bus_if.addr, bus_if.wdata);
        end
    endtask

    task automatic test_read_capture();
        int e; int r0; int d0;
        r0 = req_total; d0 = done_total;
        press(1'b0, 2'd1, 4'h5, e);
        bus_if.rdata = 8'h07;
        sw_addr = 2'd3;
        sw_we   = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_if.req !== 1'b1 || bus_if.addr !== 2'd1 || bus_if.we !== 1'b0) begin
            n_fail++; $display("FAIL read_stable: got req/addr/we %b/%h/%b required 1/1/0", bus_if.req, bus_if.addr, bus_if.we);
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        tick();
        n_checks++;
        if (req_total - r0 !== 3) begin
            n_fail++; $display("FAIL read_req_len: got %0d cycles required 3", req_total - r0);
        end
        n_checks++;
        if (rd_q !== 8'h07 || done_total - d0 !== 1) begin
            n_fail++; $display("FAIL read_capture: got rd_q=%h pulses=%0d required 07/1", rd_q, done_total - d0);
        end
        release_key();
        bus_if.rdata = 8'h99;
        bus_if.ack   = 1'b1;
        repeat (3) tick();
        bus_if.ack   = 1'b0;
        tick();
        n_checks++;
        if (rd_q !== 8'h07 || done_total - d0 !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack: got rd_q=%h pulses=%0d busy=%b required 07/1/0", rd_q, done_total - d0, busy);
        end
    endtask

    task automatic test_bounce();
        int e; int r0; int d0;
        r0 = req_total; d0 = done_total;
        sw_we = 1'b1; sw_addr = 2'd3; sw_data = 4'h3;
        key_n = 1'b0;
        repeat (3) tick();
        key_n = 1'b1;
        tick();
        press(1'b1, 2'd3, 4'h3, e);
        n_checks++;
        if (e !== 6 || req_total !== r0) begin
            n_fail++; $display("FAIL bounce_latency: got %0d edges, %0d early req cycles required 6/0", e, req_total - r0);
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (done_total - d0 !== 1 || bus_if.wdata !== 8'h03) begin
            n_fail++; $display("FAIL bounce_one_txn: got pulses=%0d wdata=%h required 1/03", done_total - d0, bus_if.wdata);
        end
        release_key();
    endtask

    task automatic test_held_key();
        int e; int r0; int d0;
        r0 = req_total; d0 = done_total;
        press(1'b1, 2'd0, 4'hF, e);
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        repeat (100) tick();
        n_checks++;
        if (req_total - r0 !== 1 || done_total - d0 !== 1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL held_no_repeat: got req=%0d pulses=%0d busy=%b required 1/1/1", req_total - r0, done_total - d0, busy);
        end
        key_n = 1'b1;
        repeat (3) tick();
        key_n = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (req_total - r0 !== 1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL short_release: got req=%0d busy=%b required 1/1", req_total - r0, busy);
        end
        release_key();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL full_release: got busy=%b required 0", busy);
        end
        press(1'b1, 2'd1, 4'h2, e);
        n_checks++;
        if (e !== 6 || bus_if.wdata !== 8'h02) begin
            n_fail++; $display("FAIL second_press: got %0d edges wdata=%h required 6/02", e, bus_if.wdata);
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        release_key();
    endtask

`ifdef REGFILE_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int e; int r0; int d0;
        r0 = req_total; d0 = done_total;
        press(1'b0, 2'd3, 4'h1, e);
        repeat (30) tick();
        n_checks++;
        if (req_total - r0 !== 15 || bus_if.req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_len: got %0d req cycles req=%b required 15/0", req_total - r0, bus_if.req);
        end
        n_checks++;
        if (err !== 1'b1 || done_total - d0 !== 0 || rd_q !== 8'h07) begin
            n_fail++; $display("FAIL timeout_flags: got err=%b pulses=%0d rd_q=%h required 1/0/07", err, done_total - d0, rd_q);
        end
        release_key();
        press(1'b1, 2'd0, 4'h4, e);
        n_checks++;
        if (err !== 1'b0 || bus_if.req !== 1'b1) begin
            n_fail++; $display("FAIL timeout_err_clear: got err=%b req=%b required 0/1", err, bus_if.req);
        end
        bus_if.ack = 1'b1;
        tick();
        bus_if.ack = 1'b0;
        release_key();
    endtask
`endif

    task automatic test_reset_mid_issue();
        int e;
        press(1'b0, 2'd2, 4'h6, e);
        n_checks++;
        if (bus_if.req !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_req: got req=%b required 1", bus_if.req);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.req !== 1'b0 || bus_if.we !== 1'b0 || bus_if.addr !== 2'd0 || bus_if.wdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_async_bus: got req/we/addr/wdata %b/%b/%h/%h required 0", bus_if.req, bus_if.we, bus_if.addr, bus_if.wdata);
        end
        n_checks++;
        if (rd_q !== 8'h00 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_out: got rd_q/done/busy/err %h/%b/%b/%b required 0", rd_q, done, busy, err);
        end
        bus_if.rdata = 8'hAA;
        bus_if.ack   = 1'b1;
        key_n        = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        bus_if.ack = 1'b0;
        tick();
        n_checks++;
        if (rd_q !== 8'h00 || bus_if.req !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_stray_ack: got rd_q=%h req=%b done=%b required 00/0/0", rd_q, bus_if.req, done);
        end
    endtask

    initial begin
        test_reset();
        test_clean_write();
        test_read_capture();
        test_bounce();
        test_held_key();
`ifdef REGFILE_INIT_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_issue();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_initiator.md
# regfile_initiator

Bus initiator for the 4×8 register file. It debounces a push-button and samples the switch settings on each press. It then issues exactly one write or read transaction to the register file over a req/ack handshake and captures the returned read data for display. It sits between the board inputs (KEY/SW) and the register file's responder port, replacing direct key-as-clock writes.

## Interface
- DEB_CYCLES, 4, number of consecutive synchronized samples needed to accept a press or a release; must be ≥1.
- TIMEOUT, 15, number of req-high cycles allowed without ack before the transaction is abandoned; must be ≥1.
- clk  in  1  single system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_n  in  1  raw push-button, active-low, asynchronous to clk.
- sw_we  in  1  1 = write, 0 = read.
- sw_addr  in  2  target register index.
- sw_data  in  4  write value, sign-extended to 8 bits.
- req  out  1  transaction request to the register file.
- we  out  1  write enable, qualified by req.
- addr  out  2  register index, qualified by req.
- wdata  out  8  write data, qualified by req && we.
- ack  in  1  single-cycle completion strobe from the register file; honoured only while req=1.
- rdata  in  8  read data; valid in the cycle ack=1.
- rd_q  out  8  last captured read data.
- done  out  1  one-cycle pulse after each acked transaction.
- busy  out  1  high in ISSUE and RELEASE.
- err  out  1  sticky timeout flag.

## Operation
- key_n passes through a 2-flop synchronizer to produce key_s. No other logic samples key_n.
- FSM states: ARM, ISSUE, RELEASE. The reset state is ARM.
- ARM:
  - Debounce counter cnt advances on each edge with key_s=0 and clears on any edge with key_s=1.
  - On the edge where key_s=0 and cnt==DEB_CYCLES-1, the block moves to ISSUE.
  - On that same edge it clears cnt, latches we←sw_we, addr←sw_addr and wdata←{{4{sw_data[3]}},sw_data}, clears err, and sets req←1.
- ISSUE:
  - req stays 1, and we/addr/wdata stay stable, until completion.
  - Edge with ack=1: req←0 and done←1 for one cycle. If we=0, rd_q←rdata; writes leave rd_q unchanged. The block moves to RELEASE.
  - Edge with ack=0: timeout counter tcnt increments (only when the timeout feature is compiled in).
- RELEASE:
  - Waits for key_s=1 on DEB_CYCLES consecutive edges. Any edge with key_s=0 restarts the count.
  - When the count completes, the block returns to ARM.
  - One press therefore yields exactly one transaction, however long the key is held.
- ack while req=0 is ignored, with no state or output change.
- we, addr and wdata hold their last values between transactions.

## Timing
- Reset values: req=0, we=0, addr=0, wdata=0, rd_q=0, done=0, busy=0, err=0. cnt, tcnt and the synchronizer are cleared, and state=ARM.
- Reset is asynchronous. Asserting rst_n mid-transaction drops req immediately, without waiting for a clock edge.
- Press latency:
  - Take edge 1 as the first edge that samples key_n=0, with key_n held low thereafter.
  - req rises after edge DEB_CYCLES+2. With the default DEB_CYCLES=4, that is after edge 6.
- Handshake:
  - If ack is high on the first edge after req rises, req falls after that edge.
  - done is high in the cycle following the ack edge.
  - The minimum req pulse is 1 cycle.
- Bounce: a key_s=1 sample in ARM before the count completes aborts the press, and no transaction is issued.
- Switches change only the latched command at the ISSUE-entry edge. Changes during ISSUE or RELEASE have no effect.

## Configuration
- Macro: REGFILE_INIT_TIMEOUT_EN.
- Defined:
  - In ISSUE, if ack has not been seen by the edge where tcnt==TIMEOUT-1, the transaction is abandoned.
  - On that edge: req←0, err←1, no done pulse, rd_q unchanged, and the block moves to RELEASE.
  - tcnt clears on ISSUE entry.
  - With TIMEOUT=15, req is high for exactly 15 cycles.
- Undefined: ISSUE waits for ack indefinitely, err is tied to 0, and no tcnt logic exists.

## Test plan
- Clean write: hold key_n=0 with sw_we=1, sw_addr=2, sw_data=4'b1010; ack on the 1st req cycle.
  - Required: req rises after edge 6, addr=2, wdata=8'hFA, done pulses once, rd_q stays 8'h00.
- Read capture: sw_we=0, sw_addr=1; responder returns rdata=8'h07 with ack on the 3rd req cycle.
  - Required: req high for exactly 3 cycles, rd_q=8'h07, done pulses once.
- Bounce rejection: key_n low for 3 synchronized cycles, high for 1, then low for 4 or more.
  - Required: exactly one transaction, issued only after the second low run.
- Held key / no repeat: key_n held low for 100 cycles, then released.
  - Required: one transaction. A second press is accepted only after 4 consecutive high samples.
- Timeout (REGFILE_INIT_TIMEOUT_EN defined): press with ack never asserted.
  - Required: req high for 15 cycles, err=1, no done pulse.
  - On the next acked press, err returns to 0 on the ISSUE-entry edge.
- Reset mid-ISSUE: drive rst_n=0 while req=1.
  - Required: req=0 immediately and all outputs at their reset values. A stray ack after reset does not change rd_q.
